gpr_wr_arbiter: RTL and testbench
=================================

// Module: gpr_wr_arbiter
// PURPOSE
//   Shares the single GPR write port among NUM_REQ writeback sources (ALU, load
//   unit, stack/IO) using round-robin arbitration. Drives the GPR w_enable/w_addr/
//   w_data pins from a registered output stage. Exposes a busy mask of registers
//   with a granted write not yet committed, for decode-stage hazard stalls.
// PARAMETERS
//   NUM_REQ  3  number of writeback requesters (2..8)
//   AW       3  register address width (8 GPRs)
//   DW       8  register data width
// PORTS
//   clk          in   1           system clock, rising edge
//   rst          in   1           asynchronous, active-high reset
//   hold         in   1           1 = issue no grants this cycle (pipeline freeze)
//   req_valid    in   NUM_REQ     per-requester write request
//   req_addr     in   NUM_REQ*AW  packed target register; requester i at [i*AW+:AW]
//   req_data     in   NUM_REQ*DW  packed write data; requester i at [i*DW+:DW]
//   req_ready    out  NUM_REQ     one-hot grant; transfer = req_valid[i] & req_ready[i]
//   w_enable     out  1           to GPR write enable (registered)
//   w_addr       out  AW          to GPR write address (registered)
//   w_data       out  DW          to GPR write data (registered)
//   busy         out  2**AW       bit r = 1: write to register r in flight
//   grant_idx    out  3           index of last granted requester (debug)
// BEHAVIOUR
//   Reset (async assert, sync release): w_enable=0, w_addr=0, w_data=0,
//     rr_ptr=0, grant_idx=0; busy=0 and req_ready=0 follow combinationally.
//   Arbitration (combinational, same cycle):
//     - hold=1 or req_valid=0 -> req_ready=0.
//     - else grant the first i with req_valid[i]=1 searching rr_ptr, rr_ptr+1, ...
//       wrapping modulo NUM_REQ; exactly one req_ready bit high.
//     - req_ready never asserted while req_valid low for that requester.
//   Pointer update (posedge): on a grant to i, rr_ptr <= (i+1) mod NUM_REQ and
//     grant_idx <= i; no grant -> rr_ptr, grant_idx unchanged.
//   Output stage (posedge), latency 1 cycle from grant:
//     - grant i: w_enable<=1, w_addr<=req_addr[i], w_data<=req_data[i].
//     - no grant: w_enable<=0; w_addr/w_data hold last values.
//     - GPR commits on the edge after w_enable is seen, i.e. data readable
//       from GPR 2 edges after the grant cycle.
//   busy = w_enable ? (1 << w_addr) : 0 (combinational from output regs).
//   Fairness: a continuously valid requester waits at most NUM_REQ-1 grant cycles
//     (hold cycles excluded). No starvation.
//   Same-address collisions: requests to one register in consecutive grants commit
//     in grant order; last granted value persists. No merging or dropping.
//   Requesters must hold valid/addr/data stable until granted; the arbiter does
//     not buffer un-granted requests.
//   hold asserted with a write in the output stage: that write still commits;
//     only new grants are blocked.
//   Reset mid-operation: in-flight output-stage write is dropped (w_enable
//     clears immediately); rr_ptr returns to 0.
//   Address 0 is not special; writes to r0 are passed through.
// TESTING
//   1 single: req_valid=3'b001, addr=5, data=8'hA5 -> req_ready=001 same cycle;
//     next cycle w_enable=1, w_addr=5, w_data=A5, busy=8'b0010_0000.
//   2 round-robin: req_valid=3'b111 held 6 cycles -> grants 0,1,2,0,1,2; each
//     requester exactly 2 grants.
//   3 wrap: rr_ptr=2, req_valid=3'b011 -> grant 0, then 1; rr_ptr ends at 2.
//   4 hold: all valid, hold=1 for 3 cycles -> req_ready=0, w_enable drops 1 cycle
//     later; release -> grant resumes from saved rr_ptr.
//   5 collision: req0 addr 3 data 11, req1 addr 3 data 22, both valid -> r3 = 22
//     after both commit; w_enable high 2 consecutive cycles.
//   6 reset: assert rst while w_enable=1 -> w_enable, busy 0 before next edge;
//     after release first grant goes to lowest valid index.

Source files
------------

// File: rtl/gpr_wr_arbiter_if.sv
// Bundle of the GPR write-port arbiter signals: requester side in, GPR pins and
// hazard/debug info out. The master side drives requests; the slave is the arbiter.
interface gpr_wr_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 3,
  parameter int DW      = 8
);
  logic                  hold;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  w_enable;
  logic [AW-1:0]         w_addr;
  logic [DW-1:0]         w_data;
  logic [(2**AW)-1:0]    busy;
  logic [2:0]            grant_idx;

  modport master (
    output hold, req_valid, req_addr, req_data,
    input  req_ready, w_enable, w_addr, w_data, busy, grant_idx
  );

  modport slave (
    input  hold, req_valid, req_addr, req_data,
    output req_ready, w_enable, w_addr, w_data, busy, grant_idx
  );
endinterface

// File: rtl/gpr_wr_arbiter.sv
// Round-robin arbiter sharing the single GPR write port among NUM_REQ writeback
// sources. Grants are combinational; the winning write is registered into the
// GPR pins one cycle later. busy flags the register targeted by the write
// currently sitting in the output stage so decode can stall on it.
module gpr_wr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 3,
  parameter int DW      = 8
) (
  input  logic             clk,
  input  logic             rst,
  gpr_wr_arbiter_if.slave  bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = 2**AW;

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [2:0]    grant_idx_q, grant_idx_d;
  logic          w_enable_q, w_enable_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic [DW-1:0] w_data_q, w_data_d;

  logic          grant_any;
  logic [PW-1:0] grant_sel;
  logic [PW:0]   cand_sum;

  logic [AW-1:0] addr_arr [NUM_REQ];
  logic [DW-1:0] data_arr [NUM_REQ];

  // Unpack the flat request buses and form the one-hot ready vector.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign addr_arr[gi]      = bus.req_addr[gi*AW +: AW];
    assign data_arr[gi]      = bus.req_data[gi*DW +: DW];
    assign bus.req_ready[gi] = grant_any && (grant_sel == PW'(gi));
  end

  // Search from rr_ptr upward (wrapping) for the first valid requester.
  // No grants while held or while reset is asserted.
  always_comb begin
    grant_any = 1'b0;
    grant_sel = '0;
    cand_sum  = '0;
    if (!rst && !bus.hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
        if (cand_sum >= (PW+1)'(NUM_REQ)) begin
          cand_sum = cand_sum - (PW+1)'(NUM_REQ);
        end
        if (!grant_any && bus.req_valid[cand_sum[PW-1:0]]) begin
          grant_any = 1'b1;
          grant_sel = cand_sum[PW-1:0];
        end
      end
    end
  end

  // Next-state for pointer, debug index and the registered write port.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    w_enable_d  = 1'b0;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    if (grant_any) begin
      rr_ptr_d    = (grant_sel == PW'(NUM_REQ-1)) ? '0 : grant_sel + PW'(1);
      grant_idx_d = 3'(grant_sel);
      w_enable_d  = 1'b1;
      w_addr_d    = addr_arr[grant_sel];
      w_data_d    = data_arr[grant_sel];
    end
  end

  // State registers; reset drops any in-flight write immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      w_enable_q  <= 1'b0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      w_enable_q  <= w_enable_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
    end
  end

  assign bus.w_enable  = w_enable_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.w_data    = w_data_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.busy      = w_enable_q ? (BW'(1) << w_addr_q) : '0;
endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// Directed bench for gpr_wr_arbiter: reset, single write, round-robin order,
// pointer wrap, hold, same-address collision and mid-operation reset.
module tb_gpr_wr_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [7:0] gpr [8];
  int   we_run;

  gpr_wr_arbiter_if #(.NUM_REQ(3), .AW(3), .DW(8)) bus ();

  gpr_wr_arbiter #(.NUM_REQ(3), .AW(3), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the external GPR file: commits whatever the write pins present.
  always @(posedge clk) begin
    if (bus.w_enable) gpr[bus.w_addr] <= bus.w_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
    bus.req_addr[i*3 +: 3] = a;
    bus.req_data[i*8 +: 8] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.hold = 1'b0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.hold = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_addr = '0;
    bus.req_data = '0;
    for (int i = 0; i < 8; i++) gpr[i] = 8'h00;
    step();
    n_cmp++; if (bus.w_enable !== 1'b0) begin n_err++; $display("FAIL reset_w_enable got %b want 0", bus.w_enable); end
    n_cmp++; if (bus.w_addr !== 3'd0) begin n_err++; $display("FAIL reset_w_addr got %0d want 0", bus.w_addr); end
    n_cmp++; if (bus.w_data !== 8'h00) begin n_err++; $display("FAIL reset_w_data got %h want 00", bus.w_data); end
    n_cmp++; if (bus.busy !== 8'h00) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL reset_req_ready got %b want 000", bus.req_ready); end
    n_cmp++; if (bus.grant_idx !== 3'd0) begin n_err++; $display("FAIL reset_grant_idx got %0d want 0", bus.grant_idx); end
    bus.req_valid = '0;
    rst = 1'b0;
    step();
    $display("txn reset: outputs idle after reset");
  endtask

  task automatic test_single();
    set_req(0, 3'd5, 8'hA5);
    bus.req_valid = 3'b001;
    #1;
    n_cmp++; if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL single_ready got %b want 001", bus.req_ready); end
    step();
    bus.req_valid = 3'b000;
    n_cmp++; if (bus.w_enable !== 1'b1) begin n_err++; $display("FAIL single_w_enable got %b want 1", bus.w_enable); end
    n_cmp++; if (bus.w_addr !== 3'd5) begin n_err++; $display("FAIL single_w_addr got %0d want 5", bus.w_addr); end
    n_cmp++; if (bus.w_data !== 8'hA5) begin n_err++; $display("FAIL single_w_data got %h want a5", bus.w_data); end
    n_cmp++; if (bus.busy !== 8'b0010_0000) begin n_err++; $display("FAIL single_busy got %b want 00100000", bus.busy); end
    step();
    n_cmp++; if (bus.w_enable !== 1'b0) begin n_err++; $display("FAIL single_idle_we got %b want 0", bus.w_enable); end
    n_cmp++; if (bus.w_addr !== 3'd5) begin n_err++; $display("FAIL single_hold_addr got %0d want 5", bus.w_addr); end
    n_cmp++; if (gpr[5] !== 8'hA5) begin n_err++; $display("FAIL single_commit got %h want a5", gpr[5]); end
    $display("txn single: req0 r5 <= a5");
  endtask

  task automatic test_round_robin();
    int cnt [3];
    logic [2:0] exp_ready;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0;
      set_req(i, 3'(i + 1), 8'(8'h10 + i));
    end
    bus.req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_ready = 3'b001 << (c % 3);
      n_cmp++; if (bus.req_ready !== exp_ready) begin n_err++; $display("FAIL rr_ready[%0d] got %b want %b", c, bus.req_ready, exp_ready); end
      for (int i = 0; i < 3; i++) if (bus.req_ready[i]) cnt[i]++;
      step();
      n_cmp++; if (bus.w_addr !== 3'((c % 3) + 1)) begin n_err++; $display("FAIL rr_w_addr[%0d] got %0d want %0d", c, bus.w_addr, (c % 3) + 1); end
      n_cmp++; if (bus.grant_idx !== 3'(c % 3)) begin n_err++; $display("FAIL rr_grant_idx[%0d] got %0d want %0d", c, bus.grant_idx, c % 3); end
      $display("txn rr: cycle %0d grant %0d", c, bus.grant_idx);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (cnt[i] !== 2) begin n_err++; $display("FAIL rr_count[%0d] got %0d want 2", i, cnt[i]); end
    end
    bus.req_valid = 3'b000;
    step();
  endtask

  task automatic test_wrap();
    // pointer is 0 here; one grant to requester 1 moves it to 2
    bus.req_valid = 3'b010;
    step();
    bus.req_valid = 3'b011;
    #1;
    n_cmp++; if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL wrap_first got %b want 001", bus.req_ready); end
    step();
    n_cmp++; if (bus.grant_idx !== 3'd0) begin n_err++; $display("FAIL wrap_idx0 got %0d want 0", bus.grant_idx); end
    n_cmp++; if (bus.req_ready !== 3'b010) begin n_err++; $display("FAIL wrap_second got %b want 010", bus.req_ready); end
    step();
    n_cmp++; if (bus.grant_idx !== 3'd1) begin n_err++; $display("FAIL wrap_idx1 got %0d want 1", bus.grant_idx); end
    bus.req_valid = 3'b111;
    #1;
    n_cmp++; if (bus.req_ready !== 3'b100) begin n_err++; $display("FAIL wrap_ptr2 got %b want 100", bus.req_ready); end
    bus.req_valid = 3'b000;
    step();
    $display("txn wrap: grants 0 then 1, pointer back at 2");
  endtask

  task automatic test_hold();
    // pointer is 2 here
    bus.req_valid = 3'b111;
    step();
    n_cmp++; if (bus.grant_idx !== 3'd2) begin n_err++; $display("FAIL hold_pre_idx got %0d want 2", bus.grant_idx); end
    bus.hold = 1'b1;
    #1;
    n_cmp++; if (bus.w_enable !== 1'b1) begin n_err++; $display("FAIL hold_inflight_we got %b want 1", bus.w_enable); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL hold_ready[%0d] got %b want 000", c, bus.req_ready); end
      step();
      n_cmp++; if (bus.w_enable !== 1'b0) begin n_err++; $display("FAIL hold_we[%0d] got %b want 0", c, bus.w_enable); end
    end
    n_cmp++; if (gpr[3] !== 8'h12) begin n_err++; $display("FAIL hold_commit got %h want 12", gpr[3]); end
    bus.hold = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 3'b001) begin n_err++; $display("FAIL hold_resume got %b want 001", bus.req_ready); end
    bus.req_valid = 3'b000;
    step();
    $display("txn hold: 3 held cycles, resumed at requester 0");
  endtask

  task automatic test_collision();
    do_reset();
    we_run = 0;
    set_req(0, 3'd3, 8'h11);
    set_req(1, 3'd3, 8'h22);
    bus.req_valid = 3'b011;
    step();
    if (bus.w_enable) we_run++;
    n_cmp++; if (bus.w_data !== 8'h11) begin n_err++; $display("FAIL coll_first got %h want 11", bus.w_data); end
    bus.req_valid = 3'b010;
    step();
    if (bus.w_enable) we_run++;
    n_cmp++; if (bus.w_data !== 8'h22) begin n_err++; $display("FAIL coll_second got %h want 22", bus.w_data); end
    bus.req_valid = 3'b000;
    step();
    step();
    n_cmp++; if (we_run !== 2) begin n_err++; $display("FAIL coll_we_run got %0d want 2", we_run); end
    n_cmp++; if (gpr[3] !== 8'h22) begin n_err++; $display("FAIL coll_r3 got %h want 22", gpr[3]); end
    $display("txn collision: r3 = %h", gpr[3]);
  endtask

  task automatic test_reset_mid();
    set_req(0, 3'd6, 8'h77);
    set_req(1, 3'd0, 8'h5C);
    set_req(2, 3'd4, 8'h99);
    bus.req_valid = 3'b001;
    step();
    n_cmp++; if (bus.w_enable !== 1'b1) begin n_err++; $display("FAIL mid_pre_we got %b want 1", bus.w_enable); end
    bus.req_valid = 3'b110;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.w_enable !== 1'b0) begin n_err++; $display("FAIL mid_we got %b want 0", bus.w_enable); end
    n_cmp++; if (bus.busy !== 8'h00) begin n_err++; $display("FAIL mid_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL mid_ready got %b want 000", bus.req_ready); end
    step();
    n_cmp++; if (gpr[6] === 8'h77) begin n_err++; $display("FAIL mid_dropped got %h want not 77", gpr[6]); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 3'b010) begin n_err++; $display("FAIL mid_first got %b want 010", bus.req_ready); end
    bus.req_valid = 3'b010;
    step();
    bus.req_valid = 3'b000;
    n_cmp++; if (bus.busy !== 8'b0000_0001) begin n_err++; $display("FAIL mid_r0_busy got %b want 00000001", bus.busy); end
    step();
    n_cmp++; if (gpr[0] !== 8'h5C) begin n_err++; $display("FAIL mid_r0_commit got %h want 5c", gpr[0]); end
    $display("txn reset_mid: write dropped, r0 <= 5c");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_hold();
    test_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
